// File: rtl/ksz_bus_pkg.sv
// ksz_bus_pkg: shared codes for the KSZ8851 command-port arbiter
package ksz_bus_pkg;
    typedef enum logic [3:0] {
        ST_ADDR0 = 4'd0, ST_ADDR1 = 4'd1, ST_ADDR2 = 4'd2, ST_ADDR3 = 4'd3,
        ST_READ0 = 4'd4, ST_READ1 = 4'd5, ST_WRITE0 = 4'd6, ST_WRITE1 = 4'd7,
        ST_DONE = 4'd8, ST_WAIT = 4'd9
    } bus_state_e;

    localparam logic [1:0] REQ_INIT = 2'd0;
    localparam logic [1:0] REQ_RX   = 2'd1;
    localparam logic [1:0] REQ_TX   = 2'd2;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_DRAIN} arb_state_e;

    function automatic logic [1:0] next_id(logic [1:0] id);
        return (id == REQ_TX) ? REQ_INIT : id + 2'd1;
    endfunction
endpackage

// File: rtl/ksz_bus_arbiter_if.sv
// ksz_bus_arbiter_if: requester fields, grant handshake and bus-engine command port
interface ksz_bus_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  rel;
    logic [2:0]  gnt;
    logic [23:0] offsetIn;
    logic [2:0]  lengthIn;
    logic [2:0]  wrIn;
    logic [47:0] writeDataIn;
    logic [2:0]  newCmdIn;
    logic [2:0]  dummyIn;
    logic [3:0]  state;
    logic [7:0]  offset;
    logic        length;
    logic        WR;
    logic [15:0] writeData;
    logic        NewCommand;
    logic        Dummy_Write;
    logic        busy;
    logic        timeout;
    logic [1:0]  timeoutOwner;

    modport slave (
        input  req, rel, offsetIn, lengthIn, wrIn, writeDataIn, newCmdIn, dummyIn, state,
        output gnt, offset, length, WR, writeData, NewCommand, Dummy_Write, busy, timeout, timeoutOwner
    );
    modport master (
        output req, rel, offsetIn, lengthIn, wrIn, writeDataIn, newCmdIn, dummyIn, state,
        input  gnt, offset, length, WR, writeData, NewCommand, Dummy_Write, busy, timeout, timeoutOwner
    );
endinterface

// File: rtl/ksz_rr_pick.sv
// ksz_rr_pick: 3-way round-robin pick starting after lastOwner
module ksz_rr_pick
    import ksz_bus_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] lastOwner,
    output logic       valid,
    output logic [1:0] id
);
    logic [1:0] c1, c2;
    always_comb begin
        c1 = next_id(lastOwner);
        c2 = next_id(c1);
        valid = |req;
        id = req[c1] ? c1 : req[c2] ? c2 : lastOwner;
    end
endmodule

// File: rtl/ksz_bus_arbiter.sv
// ksz_bus_arbiter: round-robin owner of the KSZ8851 command port with drain and watchdog
module ksz_bus_arbiter
    import ksz_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic clk40m,
    input logic reset,
    ksz_bus_arbiter_if.slave bus
);
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

    arb_state_e    fsm;
    logic [1:0]    own, last_owner, pick;
    logic          pick_valid, owner_rel, wd_hit, owned;
    logic [WW-1:0] wd;

    ksz_rr_pick u_pick (.req(bus.req), .lastOwner(last_owner), .valid(pick_valid), .id(pick));

    always_comb begin
        owner_rel = bus.rel[own];
        wd_hit = wd == WD_MAX;
        owned = fsm == ARB_GRANT;
        bus.offset = owned ? bus.offsetIn[{own, 3'b000} +: 8] : 8'd0;
        bus.length = owned & bus.lengthIn[own];
        bus.WR = owned & bus.wrIn[own];
        bus.writeData = owned ? bus.writeDataIn[{own, 4'b0000} +: 16] : 16'd0;
        bus.NewCommand = owned & bus.newCmdIn[own];
        bus.Dummy_Write = owned & bus.dummyIn[own];
    end

    always_ff @(posedge clk40m) begin
        if (reset) begin
            fsm <= ARB_IDLE;
            own <= REQ_INIT;
            last_owner <= REQ_TX;
            wd <= '0;
            bus.gnt <= 3'd0;
            bus.busy <= 1'b0;
            bus.timeout <= 1'b0;
            bus.timeoutOwner <= 2'd0;
        end else begin
            bus.timeout <= 1'b0;
            case (fsm)
                ARB_IDLE: if (pick_valid) begin
                    own <= pick;
                    bus.gnt <= 3'b001 << pick;
                    wd <= '0;
                    fsm <= ARB_GRANT;
                    bus.busy <= 1'b1;
                end
                ARB_GRANT: if (owner_rel || wd_hit) begin
                    // a release in the same cycle as expiry is a normal release
                    bus.gnt <= 3'd0;
                    last_owner <= own;
                    fsm <= ARB_DRAIN;
                    bus.timeout <= !owner_rel;
                    if (!owner_rel) bus.timeoutOwner <= own;
                end else begin
                    wd <= wd + 1'b1;
                end
                ARB_DRAIN: if (bus.state == ST_WAIT) begin
                    fsm <= ARB_IDLE;
                    bus.busy <= 1'b0;
                end
                default: fsm <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ksz_bus_arbiter.sv
// tb_ksz_bus_arbiter: vector table, corner sequences and random run against a reference model
module tb_ksz_bus_arbiter;
    localparam int TO = 16;

    logic clk40m = 1'b0;
    logic reset = 1'b1;
    always #5 clk40m = ~clk40m;

    ksz_bus_arbiter_if b ();
    ksz_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.clk40m(clk40m), .reset(reset), .bus(b));

    int n_checks = 0;
    int n_fail = 0;

    int m_owner = -1;
    bit m_drain = 0;
    int m_last = 2;
    int m_held = 0;
    bit m_to = 0;
    int m_to_owner = 0;

    typedef struct {
        logic [2:0] req;
        logic [2:0] rel;
        logic [3:0] st;
        logic [2:0] gnt;
        logic       busy;
        logic [7:0] offset;
    } vec_t;
    vec_t vecs[13];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit found;
        if (reset) begin
            m_owner = -1; m_drain = 0; m_last = 2; m_held = 0; m_to = 0; m_to_owner = 0;
            return;
        end
        m_to = 0;
        if (m_owner >= 0) begin
            if (b.rel[m_owner] || m_held == TO - 1) begin
                if (!b.rel[m_owner]) begin
                    m_to = 1;
                    m_to_owner = m_owner;
                end
                m_last = m_owner;
                m_owner = -1;
                m_drain = 1;
            end else m_held++;
        end else if (m_drain) begin
            m_drain = (b.state != 4'd9);
        end else begin
            found = 0;
            for (int k = 1; k <= 3; k++)
                if (!found && b.req[(m_last + k) % 3]) begin
                    m_owner = (m_last + k) % 3;
                    m_held = 0;
                    found = 1;
                end
        end
    endtask

    task automatic check_model();
        logic [6:0] exp_st;
        logic [27:0] exp_bus;
        exp_st = {(m_owner >= 0) ? 3'(1 << m_owner) : 3'd0, (m_owner >= 0) || m_drain, m_to, 2'(m_to_owner)};
        exp_bus = '0;
        if (m_owner >= 0)
            exp_bus = {b.offsetIn[8*m_owner +: 8], b.lengthIn[m_owner], b.wrIn[m_owner],
                       b.writeDataIn[16*m_owner +: 16], b.newCmdIn[m_owner], b.dummyIn[m_owner]};
        check("model_status", 64'({b.gnt, b.busy, b.timeout, b.timeoutOwner}), 64'(exp_st));
        check("model_bus", 64'({b.offset, b.length, b.WR, b.writeData, b.NewCommand, b.Dummy_Write}), 64'(exp_bus));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk40m);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        b.req = 3'd0; b.rel = 3'd0; b.state = 4'd9;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        b.req = 3'd0; b.rel = 3'd0; b.state = 4'd0;
        b.offsetIn = {8'h78, 8'h45, 8'h12};
        b.writeDataIn = {16'h0000, 16'hBEEF, 16'h1234};
        b.lengthIn = 3'b101; b.wrIn = 3'b100; b.newCmdIn = 3'b111; b.dummyIn = 3'b010;
        tick();
        tick();
        check("reset_status", 64'({b.gnt, b.busy, b.timeout, b.timeoutOwner}), 64'd0);
        check("reset_bus", 64'({b.offset, b.writeData, b.NewCommand}), 64'd0);
        reset = 1'b0;

        vecs[0]  = '{3'b100, 3'b000, 4'd0, 3'b100, 1'b1, 8'h78};
        vecs[1]  = '{3'b100, 3'b001, 4'd0, 3'b100, 1'b1, 8'h78};
        vecs[2]  = '{3'b000, 3'b000, 4'd0, 3'b100, 1'b1, 8'h78};
        vecs[3]  = '{3'b000, 3'b100, 4'd3, 3'b000, 1'b1, 8'h00};
        vecs[4]  = '{3'b011, 3'b000, 4'd3, 3'b000, 1'b1, 8'h00};
        vecs[5]  = '{3'b011, 3'b000, 4'd9, 3'b000, 1'b0, 8'h00};
        vecs[6]  = '{3'b011, 3'b000, 4'd9, 3'b001, 1'b1, 8'h12};
        vecs[7]  = '{3'b011, 3'b001, 4'd9, 3'b000, 1'b1, 8'h00};
        vecs[8]  = '{3'b011, 3'b000, 4'd9, 3'b000, 1'b0, 8'h00};
        vecs[9]  = '{3'b011, 3'b000, 4'd9, 3'b010, 1'b1, 8'h45};
        vecs[10] = '{3'b011, 3'b010, 4'd9, 3'b000, 1'b1, 8'h00};
        vecs[11] = '{3'b011, 3'b000, 4'd9, 3'b000, 1'b0, 8'h00};
        vecs[12] = '{3'b011, 3'b000, 4'd9, 3'b001, 1'b1, 8'h12};
        for (int i = 0; i < 13; i++) begin
            b.req = vecs[i].req; b.rel = vecs[i].rel; b.state = vecs[i].st;
            tick();
            check($sformatf("vec%0d_gnt", i), 64'(b.gnt), 64'(vecs[i].gnt));
            check($sformatf("vec%0d_busy", i), 64'(b.busy), 64'(vecs[i].busy));
            check($sformatf("vec%0d_offset", i), 64'(b.offset), 64'(vecs[i].offset));
        end

        // drain hold while the engine sits in Write1
        do_reset();
        b.req = 3'b100;
        tick();
        check("drain_newcmd_owned", 64'(b.NewCommand), 64'd1);
        b.rel = 3'b100; b.state = 4'd7;
        tick();
        b.rel = 3'b000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("drain_gnt", 64'(b.gnt), 64'd0);
            check("drain_newcmd", 64'(b.NewCommand), 64'd0);
        end
        b.state = 4'd9;
        tick();
        check("drain_exit_gnt", 64'(b.gnt), 64'd0);
        tick();
        check("drain_regrant", 64'(b.gnt), 64'b100);

        // watchdog on rx with tx pending
        do_reset();
        b.req = 3'b010; b.state = 4'd5;
        tick();
        check("wd_grant", 64'(b.gnt), 64'b010);
        b.req = 3'b110;
        for (int i = 1; i < TO; i++) begin
            tick();
            check("wd_no_timeout", 64'({b.timeout, b.gnt}), 64'b0010);
        end
        tick();
        check("wd_timeout", 64'({b.timeout, b.timeoutOwner, b.gnt}), 64'b1_01_000);
        b.state = 4'd9;
        tick();
        check("wd_pulse_end", 64'({b.timeout, b.timeoutOwner, b.gnt}), 64'b0_01_000);
        tick();
        check("wd_next_tx", 64'(b.gnt), 64'b100);

        // release coincident with expiry
        do_reset();
        b.req = 3'b010;
        tick();
        for (int i = 1; i < TO; i++) tick();
        b.rel = 3'b010;
        tick();
        check("collide", 64'({b.timeout, b.timeoutOwner, b.gnt}), 64'd0);
        b.rel = 3'b000;

        // reset mid-grant
        do_reset();
        b.req = 3'b100;
        tick();
        reset = 1'b1; b.req = 3'b111;
        tick();
        check("midreset_status", 64'({b.gnt, b.busy, b.timeout}), 64'd0);
        check("midreset_bus", 64'({b.offset, b.writeData, b.NewCommand, b.WR}), 64'd0);
        reset = 1'b0;
        tick();
        check("midreset_first", 64'(b.gnt), 64'b001);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            b.req = 3'($urandom);
            b.rel = ($urandom_range(3) == 0) ? 3'(1 << $urandom_range(2)) : 3'd0;
            b.state = $urandom_range(1) ? 4'd9 : 4'($urandom_range(8));
            b.offsetIn = 24'($urandom);
            b.writeDataIn = {16'($urandom), 32'($urandom)};
            b.lengthIn = 3'($urandom); b.wrIn = 3'($urandom);
            b.newCmdIn = 3'($urandom); b.dummyIn = 3'($urandom);
            reset = ($urandom_range(199) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
